// File: rtl/image_blend_stream_pkg.sv
// Purpose: shared types and constants for the image blend stream block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package image_blend_stream_pkg;

    // Frame-tracking FSM encoding.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } blend_state_t;

    // One guard bit above the channel width holds the carry of the two-term sum.
    localparam int SUM_GUARD_BITS = 1;

    function automatic int sum_width(input int pix_w);
        return pix_w + SUM_GUARD_BITS;
    endfunction

    // Reset weight: half of full scale, so A and B blend 50/50.
    function automatic logic [31:0] default_weight(input int pix_w);
        return 32'd1 << (pix_w - 1);
    endfunction

endpackage

// File: rtl/image_blend_stream_blend_mul.sv
// Purpose: unsigned W x W -> 2W weighting multiply, kept separate so an approximate variant can drop in.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: a = pixel sample, b = weight, p = full-width product.
module blend_mul
    import image_blend_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/image_blend_stream.sv
// Purpose: per-channel weighted blend of two pixel streams, frame tagging and frame_done pulse.
// Latency: 2 cycles from input handshake to m_valid with no backpressure.
// Backpressure: whole pipeline stalls when m_valid & !m_ready; s_ready = !m_valid | m_ready.
// Ports: cfg_* weight shadow load; s_* input beat (valid/ready); m_* output beat (valid/ready)
//        with m_last; frame_done one-cycle pulse; busy while a frame or pipeline data is live.
module image_blend_stream
    import image_blend_stream_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int CH        = 3,
    parameter int FRAME_PIX = 90000,
    parameter int SAT       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    cfg_wa,
    input  logic [PIX_W-1:0]    cfg_wb,
    input  logic                cfg_load,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CH*PIX_W-1:0] s_a,
    input  logic [CH*PIX_W-1:0] s_b,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CH*PIX_W-1:0] m_data,
    output logic                m_last,
    output logic                frame_done,
    output logic                busy
);

    localparam int                SUM_W    = sum_width(PIX_W);
    localparam int                CNT_W    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [PIX_W-1:0]  W_DEF    = PIX_W'(default_weight(PIX_W));
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_PIX - 1);

    logic                          en;
    logic                          accept;
    logic                          frame_start;
    logic                          beat_last;
    logic [PIX_W-1:0]              shadow_wa, shadow_wb;
    logic [PIX_W-1:0]              act_wa, act_wb;
    logic [PIX_W-1:0]              use_wa, use_wb;
    logic [CNT_W-1:0]              pix_cnt;
    blend_state_t                  state, state_nxt;
    logic                          s1_vld, s1_last;
    logic [CH-1:0][PIX_W-1:0]      s1_pa, s1_pb;
    logic [CH-1:0][2*PIX_W-1:0]    prod_a, prod_b;
    logic [CH-1:0][SUM_W-1:0]      raw_sum;
    logic [CH-1:0][PIX_W-1:0]      sum_dat;
    logic                          unused_prod_lo;

    assign en          = !m_valid || m_ready;
    assign s_ready     = en;
    assign accept      = s_valid && en;
    assign frame_start = (pix_cnt == '0);
    assign beat_last   = (pix_cnt == CNT_LAST);
    assign busy        = (state == ST_ACTIVE) || s1_vld || m_valid;

    // The first beat of a frame latches new weights; a cfg_load in that same
    // cycle bypasses the shadow so the new values already apply to this frame.
    always_comb begin
        use_wa = act_wa;
        use_wb = act_wb;
        if (frame_start) begin
            use_wa = cfg_load ? cfg_wa : shadow_wa;
            use_wb = cfg_load ? cfg_wb : shadow_wb;
        end
    end

    for (genvar ch = 0; ch < CH; ch++) begin : g_ch
        blend_mul #(.W(PIX_W)) u_mul_a (
            .a (s_a[ch*PIX_W +: PIX_W]),
            .b (use_wa),
            .p (prod_a[ch])
        );
        blend_mul #(.W(PIX_W)) u_mul_b (
            .a (s_b[ch*PIX_W +: PIX_W]),
            .b (use_wb),
            .p (prod_b[ch])
        );
        assign raw_sum[ch] = SUM_W'(s1_pa[ch]) + SUM_W'(s1_pb[ch]);
        assign sum_dat[ch] = ((SAT != 0) && raw_sum[ch][PIX_W]) ? {PIX_W{1'b1}}
                                                                 : raw_sum[ch][PIX_W-1:0];
    end

    // Products are truncated to their upper half; the fraction bits are discarded.
    assign unused_prod_lo = ^{prod_a, prod_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_wa  <= W_DEF;
            shadow_wb  <= W_DEF;
            act_wa     <= W_DEF;
            act_wb     <= W_DEF;
            pix_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            s1_pa      <= '0;
            s1_pb      <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (cfg_load) begin
                shadow_wa <= cfg_wa;
                shadow_wb <= cfg_wb;
            end
            if (accept) begin
                pix_cnt <= beat_last ? '0 : pix_cnt + 1'b1;
                if (frame_start) begin
                    act_wa <= use_wa;
                    act_wb <= use_wb;
                end
            end
            frame_done <= m_valid && m_ready && m_last;
            if (en) begin
                s1_vld <= s_valid;
                if (s_valid) begin
                    s1_last <= beat_last;
                    for (int ch = 0; ch < CH; ch++) begin
                        s1_pa[ch] <= prod_a[ch][2*PIX_W-1:PIX_W];
                        s1_pb[ch] <= prod_b[ch][2*PIX_W-1:PIX_W];
                    end
                end
                m_valid <= s1_vld;
                m_last  <= s1_vld && s1_last;
                if (s1_vld) begin
                    m_data <= sum_dat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && !beat_last) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (accept && beat_last)  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

endmodule
